fu_result_buffer: RTL and testbench
===================================

# fu_result_buffer

Per-functional-unit completion buffer sitting directly upstream of the CDB arbiter: one instance per FU lane (ALU, MULT0, MULT1, LS, BR). Captures results the FU produces, holds them in a small in-order FIFO until the CDB grants that lane, and presents the head entry as the lane's done/tag/value request. Provides backpressure to the FU, squash on mispredict, and a starvation flag for the fixed-priority CDB.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2
- FU_ID, ALU_FU: lane's FU opcode (3 bits) as driven on CDB fu_opcode
- STARVE_LIMIT, 8: head wait cycles before urgent asserts; ≥1

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fu_valid  in  1  FU has a completed result this cycle
- fu_tag  in  TAG_SIZE  destination tag of result
- fu_packet  in  EX_MEM_PACKET  result packet (alu_result, take_branch, ...)
- squash  in  1  mispredict flush; discard all held results
- cdb_valid  in  1  CDB broadcast valid this cycle
- cdb_fu_opcode  in  3  lane CDB selected this cycle
- done  out  1  buffer non-empty; head is a CDB request
- tag  out  TAG_SIZE  head entry tag
- packet  out  EX_MEM_PACKET  head entry packet
- full  out  1  count == DEPTH; FU must stall
- count  out  $clog2(DEPTH+1)  occupied entries
- urgent  out  1  head waited ≥ STARVE_LIMIT cycles
- overflow  out  1  sticky: push attempted while full

## Operation

- grant = cdb_valid && (cdb_fu_opcode == FU_ID).
- Circular FIFO: head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count separate.
- Push: fu_valid && !full && !squash → write {fu_tag, fu_packet} at tail, tail+1.
- Pop: grant && done && !squash → head+1.
- Push and pop same cycle: both occur, count unchanged.
- Push while full: entry dropped, overflow set (sticky until reset); pop in same cycle still occurs. full is not relieved by a concurrent pop (no comb path fu_valid↔grant).
- Grant while empty: ignored, no state change.
- Squash: head=tail=0, count=0, wait counter=0; concurrent fu_valid and grant ignored. overflow not cleared.
- Wait counter: increments each cycle done && !grant, saturates at STARVE_LIMIT; clears to 0 on pop, squash, or while empty. urgent = (wait ≥ STARVE_LIMIT).
- Head entry valid for a new head starts with wait=0.
- tag/packet when empty: hold last-read storage, don't-care; consumers qualify with done.

## Timing

- Reset values: done=0, full=0, count=0, urgent=0, overflow=0, tag=0, packet all-zero (storage cleared on reset).
- done, tag, packet, full, count, urgent, overflow are functions of registers only; no combinational path from any input.
- Latency: result pushed at edge N visible as done/tag/packet in cycle N+1 (minimum one cycle FU→CDB).
- Pop takes effect at the edge where grant is sampled; next entry (if any) presented the following cycle, enabling one broadcast per cycle back-to-back.
- urgent rises in the cycle after the STARVE_LIMIT-th ungranted cycle of the same head.
- Reset asserted mid-operation: all state cleared asynchronously; outputs at reset values immediately, held until first edge after deassertion.

## Test plan

- Single result: FU_ID=ALU_FU, push tag=5 alu_result=32'h1234 at cycle 0, grant cycle 1 → done=1, tag=5 in cycle 1; done=0, count=0 in cycle 2.
- Fill and stall: 4 pushes (tags 1–4), no grant → count=4, full=1; 5th push tag=9 → dropped, overflow=1; subsequent grants pop 1,2,3,4 in order, tag 9 never appears.
- Simultaneous push/pop with wrap: DEPTH=4, steady push+grant every cycle for 10 cycles, tags 0–9 → count stays 1, output tags follow input by one cycle, pointers wrap without loss.
- Grant filtering: done=1, cdb_valid=1 with cdb_fu_opcode=MULT0_FU → no pop; with FU_ID → pop.
- Starvation: STARVE_LIMIT=8, head held ungranted 8 cycles → urgent=1 from cycle 9; grant → urgent=0 next cycle; new head wait restarts at 0.
- Squash and reset: 3 entries held, squash with concurrent fu_valid → count=0, done=0, pushed entry absent, overflow unchanged; assert reset mid-stream → all outputs zero without a clock edge.

Source files
------------

// File: rtl/fu_result_buffer.sv
// Per-FU completion buffer feeding the CDB arbiter: an in-order FIFO of
// {tag, packet} results with backpressure, squash and a starvation flag.
package fu_result_buffer_pkg;
    localparam int TAG_SIZE = 6;

    localparam logic [2:0] ALU_FU   = 3'd1;
    localparam logic [2:0] MULT0_FU = 3'd2;
    localparam logic [2:0] MULT1_FU = 3'd3;
    localparam logic [2:0] LS_FU    = 3'd4;
    localparam logic [2:0] BR_FU    = 3'd5;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] npc;
        logic        take_branch;
    } ex_mem_packet_t;
endpackage

module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int         DEPTH        = 4,
    parameter logic [2:0] FU_ID        = ALU_FU,
    parameter int         STARVE_LIMIT = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fu_valid,
    input  logic [TAG_SIZE-1:0]          fu_tag,
    input  ex_mem_packet_t               fu_packet,
    input  logic                         squash,
    input  logic                         cdb_valid,
    input  logic [2:0]                   cdb_fu_opcode,
    output logic                         done,
    output logic [TAG_SIZE-1:0]          tag,
    output ex_mem_packet_t               packet,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         urgent,
    output logic                         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [WW-1:0]       wait_q, wait_d;
    logic                overflow_q, overflow_d;
    logic [TAG_SIZE-1:0] tag_mem_q [DEPTH];
    logic [TAG_SIZE-1:0] tag_mem_d [DEPTH];
    ex_mem_packet_t      pkt_mem_q [DEPTH];
    ex_mem_packet_t      pkt_mem_d [DEPTH];

    logic grant;
    logic push;
    logic pop;

    // Outputs come from registers only; full is never relieved by a same-cycle pop.
    assign done     = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign urgent   = (wait_q >= WW'(STARVE_LIMIT));
    assign overflow = overflow_q;
    assign tag      = tag_mem_q[head_q];
    assign packet   = pkt_mem_q[head_q];

    always_comb begin
        grant      = cdb_valid && (cdb_fu_opcode == FU_ID);
        push       = fu_valid && !full && !squash;
        pop        = grant && done && !squash;

        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        wait_d     = wait_q;
        overflow_d = overflow_q | (fu_valid && full && !squash);
        tag_mem_d  = tag_mem_q;
        pkt_mem_d  = pkt_mem_q;

        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            wait_d  = '0;
        end else begin
            if (push) begin
                tag_mem_d[tail_q] = fu_tag;
                pkt_mem_d[tail_q] = fu_packet;
                tail_d            = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // A new head always starts its wait from zero.
            if (!done || pop) begin
                wait_d = '0;
            end else if (!grant && (wait_q < WW'(STARVE_LIMIT))) begin
                wait_d = wait_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= '0;
                pkt_mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wait_q     <= wait_d;
            overflow_q <= overflow_d;
            tag_mem_q  <= tag_mem_d;
            pkt_mem_q  <= pkt_mem_d;
        end
    end

endmodule

// File: tb/tb_fu_result_buffer.sv
// Bench for fu_result_buffer: directed vector table, hand-written corner
// sequences and random traffic checked against a queue-based reference model.
module tb_fu_result_buffer;
    import fu_result_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                fu_valid;
    logic [TAG_SIZE-1:0] fu_tag;
    ex_mem_packet_t      fu_packet;
    logic                squash;
    logic                cdb_valid;
    logic [2:0]          cdb_fu_opcode;
    logic                done;
    logic [TAG_SIZE-1:0] tag;
    ex_mem_packet_t      packet;
    logic                full;
    logic [2:0]          count;
    logic                urgent;
    logic                overflow;

    always #5 clock = ~clock;

    fu_result_buffer #(.DEPTH(DEPTH), .FU_ID(ALU_FU), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag),
        .fu_packet(fu_packet), .squash(squash), .cdb_valid(cdb_valid),
        .cdb_fu_opcode(cdb_fu_opcode), .done(done), .tag(tag), .packet(packet),
        .full(full), .count(count), .urgent(urgent), .overflow(overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ex_mem_packet_t mk_pkt(input logic [31:0] r);
        ex_mem_packet_t p;
        p.alu_result  = r;
        p.npc         = ~r;
        p.take_branch = r[0];
        return p;
    endfunction

    // Reference model: an ordered list of held results plus a starvation age.
    typedef struct packed {
        logic [TAG_SIZE-1:0] tag;
        ex_mem_packet_t      pkt;
    } entry_t;

    entry_t mq[$];
    bit     m_ovf;
    int     m_wait;

    function automatic void model_reset();
        mq.delete();
        m_ovf  = 0;
        m_wait = 0;
    endfunction

    function automatic void model_step(input logic fv, input logic [TAG_SIZE-1:0] tg,
                                       input ex_mem_packet_t pk, input logic sq,
                                       input logic cv, input logic [2:0] op);
        bit g  = cv && (op == ALU_FU);
        int sz = mq.size();
        entry_t e;
        if (sq) begin
            mq.delete();
            m_wait = 0;
            return;
        end
        if (fv && sz == DEPTH) m_ovf = 1;
        if (sz > 0 && !g) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
        else              m_wait = 0;
        if (g && sz > 0) void'(mq.pop_front());
        if (fv && sz < DEPTH) begin
            e.tag = tg;
            e.pkt = pk;
            mq.push_back(e);
        end
    endfunction

    task automatic model_check();
        chk("m_done", done, mq.size() > 0);
        chk("m_count", count, mq.size());
        chk("m_full", full, mq.size() == DEPTH);
        chk("m_urgent", urgent, m_wait >= LIMIT);
        chk("m_overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
            chk("m_tag", tag, mq[0].tag);
            chk("m_packet", packet, mq[0].pkt);
        end
    endtask

    task automatic cycle(input logic fv, input logic [TAG_SIZE-1:0] tg, input ex_mem_packet_t pk,
                         input logic sq, input logic cv, input logic [2:0] op);
        fu_valid      = fv;
        fu_tag        = tg;
        fu_packet     = pk;
        squash        = sq;
        cdb_valid     = cv;
        cdb_fu_opcode = op;
        @(posedge clock);
        model_step(fv, tg, pk, sq, cv, op);
        #1;
        model_check();
    endtask

    task automatic idle_cycle(input logic cv);
        cycle(1'b0, '0, '0, 1'b0, cv, ALU_FU);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_done"}, done, 0);
        chk({name, "_full"}, full, 0);
        chk({name, "_count"}, count, 0);
        chk({name, "_urgent"}, urgent, 0);
        chk({name, "_overflow"}, overflow, 0);
        chk({name, "_tag"}, tag, 0);
        chk({name, "_packet"}, packet, 0);
    endtask

    typedef struct {
        logic                fv;
        logic [TAG_SIZE-1:0] tg;
        logic [31:0]         res;
        logic                sq;
        logic                cv;
        logic [2:0]          op;
        logic                e_done;
        logic [TAG_SIZE-1:0] e_tag;
        logic [31:0]         e_res;
        logic [2:0]          e_count;
        logic                e_full;
        logic                e_urg;
        logic                e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fv, input int tg, input logic [31:0] res, input logic sq,
                       input logic cv, input logic [2:0] op, input logic e_done, input int e_tag,
                       input logic [31:0] e_res, input int e_count, input logic e_full,
                       input logic e_urg, input logic e_ovf);
        vec_t v;
        v.fv = fv; v.tg = TAG_SIZE'(tg); v.res = res; v.sq = sq; v.cv = cv; v.op = op;
        v.e_done = e_done; v.e_tag = TAG_SIZE'(e_tag); v.e_res = e_res;
        v.e_count = 3'(e_count); v.e_full = e_full; v.e_urg = e_urg; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    initial begin
        fu_valid = 0; fu_tag = '0; fu_packet = '0; squash = 0; cdb_valid = 0;
        cdb_fu_opcode = '0;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single result.
        add(1, 5, 32'h1234, 0, 0, ALU_FU,   1, 5, 32'h1234, 1, 0, 0, 0);
        add(0, 0, 32'h0,    0, 1, ALU_FU,   0, 0, 32'h0,    0, 0, 0, 0);
        // Squash with three held entries and a concurrent push and grant.
        add(1, 1, 32'h11,   0, 0, ALU_FU,   1, 1, 32'h11,   1, 0, 0, 0);
        add(1, 2, 32'h22,   0, 0, ALU_FU,   1, 1, 32'h11,   2, 0, 0, 0);
        add(1, 3, 32'h33,   0, 0, ALU_FU,   1, 1, 32'h11,   3, 0, 0, 0);
        add(1, 6, 32'h66,   1, 1, ALU_FU,   0, 0, 32'h0,    0, 0, 0, 0);
        add(0, 0, 32'h0,    0, 0, ALU_FU,   0, 0, 32'h0,    0, 0, 0, 0);
        // Fill, overflow, push+pop while full, grant filtering, drain.
        add(1, 1, 32'h101,  0, 0, ALU_FU,   1, 1, 32'h101,  1, 0, 0, 0);
        add(1, 2, 32'h102,  0, 0, ALU_FU,   1, 1, 32'h101,  2, 0, 0, 0);
        add(1, 3, 32'h103,  0, 0, ALU_FU,   1, 1, 32'h101,  3, 0, 0, 0);
        add(1, 4, 32'h104,  0, 0, ALU_FU,   1, 1, 32'h101,  4, 1, 0, 0);
        add(1, 9, 32'h109,  0, 0, ALU_FU,   1, 1, 32'h101,  4, 1, 0, 1);
        add(1, 10, 32'h10a, 0, 1, ALU_FU,   1, 2, 32'h102,  3, 0, 0, 1);
        add(0, 0, 32'h0,    0, 1, ALU_FU,   1, 3, 32'h103,  2, 0, 0, 1);
        add(0, 0, 32'h0,    0, 1, MULT0_FU, 1, 3, 32'h103,  2, 0, 0, 1);
        add(0, 0, 32'h0,    0, 0, ALU_FU,   1, 3, 32'h103,  2, 0, 0, 1);
        add(0, 0, 32'h0,    0, 1, ALU_FU,   1, 4, 32'h104,  1, 0, 0, 1);
        add(0, 0, 32'h0,    0, 1, ALU_FU,   0, 0, 32'h0,    0, 0, 0, 1);
        add(0, 0, 32'h0,    0, 1, ALU_FU,   0, 0, 32'h0,    0, 0, 0, 1);

        foreach (vecs[i]) begin
            cycle(vecs[i].fv, vecs[i].tg, mk_pkt(vecs[i].res), vecs[i].sq, vecs[i].cv, vecs[i].op);
            chk("tbl_done", done, vecs[i].e_done);
            chk("tbl_count", count, vecs[i].e_count);
            chk("tbl_full", full, vecs[i].e_full);
            chk("tbl_urgent", urgent, vecs[i].e_urg);
            chk("tbl_overflow", overflow, vecs[i].e_ovf);
            if (vecs[i].e_done) begin
                chk("tbl_tag", tag, vecs[i].e_tag);
                chk("tbl_result", packet.alu_result, vecs[i].e_res);
            end
        end

        // Steady push+grant every cycle across pointer wrap.
        cycle(1'b1, '0, mk_pkt(32'd0), 1'b0, 1'b0, ALU_FU);
        chk("wrap_first_tag", tag, 0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, TAG_SIZE'(i), mk_pkt(32'(i)), 1'b0, 1'b1, ALU_FU);
            chk("wrap_count", count, 1);
            chk("wrap_tag", tag, i);
            chk("wrap_result", packet.alu_result, i);
        end
        idle_cycle(1'b1);
        chk("wrap_drained", done, 0);

        // Starvation: urgent after LIMIT ungranted cycles of the same head.
        cycle(1'b1, TAG_SIZE'(7), mk_pkt(32'h7), 1'b0, 1'b0, ALU_FU);
        cycle(1'b1, TAG_SIZE'(8), mk_pkt(32'h8), 1'b0, 1'b0, ALU_FU);
        chk("starve_urgent_early", urgent, 0);
        for (int j = 1; j <= 7; j++) begin
            idle_cycle(1'b0);
            chk("starve_urgent", urgent, j == 7);
        end
        idle_cycle(1'b0);
        chk("starve_urgent_sat", urgent, 1);
        idle_cycle(1'b1);
        chk("starve_after_pop", urgent, 0);
        chk("starve_new_head", tag, 8);
        for (int j = 1; j <= 8; j++) begin
            idle_cycle(1'b0);
            chk("starve_new_urgent", urgent, j == 8);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        chk("starve_empty", done, 0);

        // Asynchronous reset mid-stream, observed without any clock edge.
        cycle(1'b1, TAG_SIZE'(1), mk_pkt(32'h51), 1'b0, 1'b0, ALU_FU);
        cycle(1'b1, TAG_SIZE'(2), mk_pkt(32'h52), 1'b0, 1'b0, ALU_FU);
        fu_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_zero("async_reset");
        @(posedge clock);
        #1;
        check_zero("reset_held");
        reset = 1'b0;

        // Random traffic with a grant rate that varies per block.
        for (int b = 0; b < 15; b++) begin
            int gp = $urandom_range(10, 90);
            int vp = $urandom_range(20, 90);
            for (int k = 0; k < 200; k++) begin
                logic          fv = ($urandom_range(0, 99) < vp);
                logic          sq = ($urandom_range(0, 59) == 0);
                logic          cv = ($urandom_range(0, 99) < gp);
                logic [2:0]    op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5)) : ALU_FU;
                cycle(fv, TAG_SIZE'($urandom), mk_pkt($urandom), sq, cv, op);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
